// File: rtl/arbt_wrr.sv
// Weighted round-robin / fixed-priority arbiter merging ARBT_WIDTH requesters onto one registered output stage.
// Latency: 1 cycle from capture (gnt_o high) to rdy_o; sustains one transfer per cycle with ack_i held high.
// Backpressure: while rdy_o && !ack_i the output holds and no grant is issued; requesters keep req_i up until granted.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   data_i, req_i     per-requester data word and request (held until granted)
//   gnt_o             combinational grant, high in the cycle data_i[i] is captured
//   wght_i, mode_i    per-requester burst weight (0 acts as 1); 0 = weighted RR, 1 = fixed priority
//   data_o, idx_o     registered winning data and the index of its requester
//   rdy_o, ack_i      output valid / consumer accept
module arbt_wrr #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ARBT_WIDTH = 4,
    parameter int                    WGHT_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{1'b0}}
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         data_i [0:ARBT_WIDTH-1],
    input  logic [ARBT_WIDTH-1:0]         req_i,
    output logic [ARBT_WIDTH-1:0]         gnt_o,
    input  logic [WGHT_WIDTH-1:0]         wght_i [0:ARBT_WIDTH-1],
    input  logic                          mode_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [$clog2(ARBT_WIDTH)-1:0] idx_o,
    output logic                          rdy_o,
    input  logic                          ack_i
);

    localparam int            IW   = $clog2(ARBT_WIDTH);
    localparam logic [IW-1:0] LAST = IW'(ARBT_WIDTH - 1);

    // Arbitration state. The pointer always holds the last winner, which is
    // also the burst owner whenever own_vld_q is set.
    logic [IW-1:0]         ptr_q;
    logic                  own_vld_q;
    logic [WGHT_WIDTH-1:0] cred_q;

    // Output stage
    logic [DATA_WIDTH-1:0] data_q;
    logic [IW-1:0]         idx_q;
    logic                  rdy_q;

    logic                  any_req;
    logic                  cap;
    logic                  burst;
    logic [IW-1:0]         fp_win;
    logic [IW-1:0]         rr_win;
    logic [IW-1:0]         win;
    logic [WGHT_WIDTH-1:0] w_sel;
    logic [WGHT_WIDTH-1:0] cred_fresh;

    // Fixed priority: lowest requesting index.
    always_comb begin : fp_pick
        logic [IW-1:0] c;
        logic          found;
        c      = '0;
        found  = 1'b0;
        fp_win = '0;
        for (int k = 0; k < ARBT_WIDTH; k++) begin
            if (!found && req_i[c]) begin
                fp_win = c;
                found  = 1'b1;
            end
            c = c + 1'b1;
        end
    end

    // Round-robin search: pointer+1 upward, wrapping at ARBT_WIDTH-1 (not at
    // 2**IW) so non-power-of-two widths never visit a nonexistent requester.
    // The last candidate examined is the pointer itself.
    always_comb begin : rr_pick
        logic [IW-1:0] c;
        logic          found;
        c      = ptr_q;
        found  = 1'b0;
        rr_win = '0;
        for (int k = 0; k < ARBT_WIDTH; k++) begin
            c = (c == LAST) ? '0 : c + 1'b1;
            if (!found && req_i[c]) begin
                rr_win = c;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req_i;
    assign cap     = (!rdy_q || ack_i) && any_req && !rst_i;
    // A burst continues only while the owner still requests; a dropped request
    // falls through to a fresh search and the leftover credit is overwritten.
    assign burst   = own_vld_q && (cred_q != '0) && req_i[ptr_q];
    assign win     = mode_i ? fp_win : (burst ? ptr_q : rr_win);

    // Weight is sampled only on a fresh win; the win itself uses one grant.
    assign w_sel      = wght_i[win];
    assign cred_fresh = (w_sel == '0) ? '0 : w_sel - 1'b1;

    always_comb begin
        gnt_o = '0;
        if (cap) gnt_o[win] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= LAST;
            own_vld_q <= 1'b0;
            cred_q    <= '0;
            data_q    <= RESET_VAL;
            idx_q     <= '0;
            rdy_q     <= 1'b0;
        end else if (cap) begin
            data_q <= data_i[win];
            idx_q  <= win;
            rdy_q  <= 1'b1;
            ptr_q  <= win;
            if (mode_i) begin
                cred_q    <= '0;
                own_vld_q <= 1'b0;
            end else if (burst) begin
                cred_q    <= cred_q - 1'b1;
                own_vld_q <= (cred_q != WGHT_WIDTH'(1));
            end else begin
                cred_q    <= cred_fresh;
                own_vld_q <= 1'b1;
            end
        end else if (rdy_q && ack_i) begin
            rdy_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign idx_o  = idx_q;
    assign rdy_o  = rdy_q;

    gnt_onehot0_a: assert property (@(posedge clk_i) $onehot0(gnt_o));
    gnt_has_req_a: assert property (@(posedge clk_i) (gnt_o & ~req_i) == '0);
    stall_hold_a:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    rdy_q && !ack_i |=> $stable(data_q) && $stable(idx_q));
    cred_no_uf_a:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    cap && !mode_i && burst |-> cred_q != '0);

endmodule

// File: tb/tb_arbt_wrr.sv
// Directed bench for arbt_wrr: hand-computed winner sequences pushed to a scoreboard, popped by an output monitor.
// Latency: expected entries are pushed at grant time and consumed when rdy_o && ack_i is seen.
// Backpressure: stall phases hold ack low and check the held output against the scoreboard head.
module tb_arbt_wrr;
    localparam int              DW  = 32;
    localparam int              N   = 4;
    localparam int              WW  = 4;
    localparam logic [DW-1:0]   RV4 = 32'hDEAD_0000;
    localparam logic [DW-1:0]   RV3 = 32'h0BAD_0003;

    typedef struct { int idx; logic [DW-1:0] dat; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-requester instance
    logic          rst, mode, ack, rdy;
    logic [DW-1:0] din [N];
    logic [WW-1:0] w   [N];
    logic [N-1:0]  req, gnt;
    logic [DW-1:0] dout;
    logic [1:0]    idx;

    // 3-requester instance (non-power-of-two wrap)
    logic          rst3, rdy3;
    logic [DW-1:0] din3 [3];
    logic [WW-1:0] w3   [3];
    logic [2:0]    req3, gnt3;
    logic [DW-1:0] dout3;
    logic [1:0]    idx3;

    arbt_wrr #(.DATA_WIDTH(DW), .ARBT_WIDTH(N), .WGHT_WIDTH(WW), .RESET_VAL(RV4)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(din), .req_i(req), .gnt_o(gnt), .wght_i(w),
        .mode_i(mode), .data_o(dout), .idx_o(idx), .rdy_o(rdy), .ack_i(ack)
    );

    arbt_wrr #(.DATA_WIDTH(DW), .ARBT_WIDTH(3), .WGHT_WIDTH(WW), .RESET_VAL(RV3)) dut3 (
        .clk_i(clk), .rst_i(rst3), .data_i(din3), .req_i(req3), .gnt_o(gnt3), .wght_i(w3),
        .mode_i(1'b0), .data_o(dout3), .idx_o(idx3), .rdy_o(rdy3), .ack_i(1'b1)
    );

    exp_t q4[$];
    exp_t q3[$];
    exp_t m4, m3;
    int   errs   = 0;
    int   checks = 0;
    int   tag    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Fresh, distinct data words every cycle so a stale capture is visible.
    task automatic new_data();
        for (int i = 0; i < N; i++) din[i] = {8'hC0, 16'(tag), 8'(i)};
        for (int i = 0; i < 3; i++) din3[i] = {8'h30, 16'(tag), 8'(i)};
        tag++;
    endtask

    // Output monitors: every accepted output must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rdy && ack) begin
            checks++;
            if (q4.size() == 0) begin
                errs++;
                $display("FAIL out4_unexpected: got idx %0d, expected no output", idx);
            end else begin
                checks--;
                m4 = q4.pop_front();
                chk("out4_idx", 64'(idx), 64'(m4.idx));
                chk("out4_data", 64'(dout), 64'(m4.dat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst3 && rdy3) begin
            checks++;
            if (q3.size() == 0) begin
                errs++;
                $display("FAIL out3_unexpected: got idx %0d, expected no output", idx3);
            end else begin
                checks--;
                m3 = q3.pop_front();
                chk("out3_idx", 64'(idx3), 64'(m3.idx));
                chk("out3_data", 64'(dout3), 64'(m3.dat));
            end
        end
    end

    // One cycle: check the grant (ew < 0 means no grant), log the expected output.
    task automatic cyc(input int ew);
        logic [N-1:0] eg;
        eg = '0;
        if (ew >= 0) eg[ew] = 1'b1;
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(eg));
        if (ew >= 0) q4.push_back('{ew, din[ew]});
        @(posedge clk);
        #1;
        new_data();
    endtask

    task automatic cyc3(input int ew);
        logic [2:0] eg;
        eg = '0;
        if (ew >= 0) eg[ew] = 1'b1;
        @(negedge clk);
        chk("gnt3", 64'(gnt3), 64'(eg));
        if (ew >= 0) q3.push_back('{ew, din3[ew]});
        @(posedge clk);
        #1;
        new_data();
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '1; ack = 1'b1; mode = 1'b0;
        @(negedge clk);
        chk("gnt_in_reset", 64'(gnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; req = '0;
        q4.delete();
        chk("rst_rdy", 64'(rdy), 64'(0));
        chk("rst_data", 64'(dout), 64'(RV4));
        chk("rst_idx", 64'(idx), 64'(0));
    endtask

    task automatic drain();
        req = '0;
        cyc(-1);
        chk("drained", 64'(q4.size()), 64'(0));
    endtask

    int s2[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

    initial begin
        rst = 1'b1; rst3 = 1'b1; mode = 1'b0; ack = 1'b1;
        req = '0; req3 = '0;
        for (int i = 0; i < N; i++) w[i] = 4'd1;
        for (int i = 0; i < 3; i++) w3[i] = 4'd1;
        new_data();

        // Plain round robin, weights 1
        do_reset();
        req = '1;
        cyc(0);
        chk("rdy_after_first", 64'(rdy), 64'(1));
        cyc(1); cyc(2); cyc(3); cyc(0);
        drain();

        // Weighted bursts {3,1,2,1}
        do_reset();
        w[0] = 4'd3; w[1] = 4'd1; w[2] = 4'd2; w[3] = 4'd1;
        req = '1;
        for (int i = 0; i < 10; i++) cyc(s2[i]);
        drain();

        // Abandoned burst, then a fresh full credit; weight change mid-burst ignored
        do_reset();
        w[0] = 4'd4; w[1] = 4'd1; w[2] = 4'd1; w[3] = 4'd1;
        req = 4'b0101;
        cyc(0); cyc(0);
        req = 4'b0100;
        cyc(2);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            cyc(0);
            if (i == 0) w[0] = 4'd1;
        end
        cyc(2);
        drain();

        // Stall for 5 cycles with everyone requesting
        do_reset();
        for (int i = 0; i < N; i++) w[i] = 4'd1;
        req = '1;
        cyc(0); cyc(1);
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(-1);
            chk("stall_rdy", 64'(rdy), 64'(1));
            chk("stall_idx", 64'(idx), 64'(1));
            if (q4.size() > 0) chk("stall_data", 64'(dout), 64'(q4[0].dat));
            else chk("stall_queue", 64'(q4.size()), 64'(1));
        end
        ack = 1'b1;
        cyc(2); cyc(3);
        drain();

        // Fixed priority, then back to RR from the pointer left at 1
        do_reset();
        mode = 1'b1;
        req = 4'b0110;
        cyc(1); cyc(1); cyc(1);
        mode = 1'b0;
        cyc(2); cyc(1);
        drain();

        // Three requesters: wrap, reset mid-stream, restart at 0
        chk("rst3_rdy", 64'(rdy3), 64'(0));
        chk("rst3_data", 64'(dout3), 64'(RV3));
        rst3 = 1'b0;
        req3 = 3'b111;
        cyc3(0); cyc3(1); cyc3(2); cyc3(0); cyc3(1);
        rst3 = 1'b1;
        cyc3(-1);
        chk("midrst3_rdy", 64'(rdy3), 64'(0));
        chk("midrst3_data", 64'(dout3), 64'(RV3));
        chk("midrst3_idx", 64'(idx3), 64'(0));
        q3.delete();
        rst3 = 1'b0;
        cyc3(0); cyc3(1);
        req3 = '0;
        cyc3(-1);
        chk("drained3", 64'(q3.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/arbt_wrr.md
Name: arbt_wrr

Overview:
Parametrised weighted round-robin arbiter with a registered single-entry output stage. It merges ARBT_WIDTH requester channels onto one data stream. Each requester gets a run-time burst weight, and a run-time mode selects weighted round-robin or fixed priority. It sits wherever several producers share one consumer: bus masters onto an interconnect port, or multiple queues onto one pipeline stage. It sustains one transfer per cycle.

Parameters:
DATA_WIDTH, 32, width of each data word
ARBT_WIDTH, 4, number of requesters; any value >= 2, not restricted to powers of two
WGHT_WIDTH, 4, width of per-requester weight and of the burst credit counter
RESET_VAL, {DATA_WIDTH{1'b0}}, reset value of data_o

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  reset; synchronous, active-high
data_i  in  DATA_WIDTH x [0:ARBT_WIDTH-1]  requester data
req_i  in  1 x [0:ARBT_WIDTH-1]  requester valid; held until granted
gnt_o  out  1 x [0:ARBT_WIDTH-1]  combinational; high in the cycle data_i[i] is captured
wght_i  in  WGHT_WIDTH x [0:ARBT_WIDTH-1]  burst weight in RR mode; 0 is treated as 1
mode_i  in  1  0 = weighted round-robin, 1 = fixed priority (lowest index wins)
data_o  out  DATA_WIDTH  registered selected data
idx_o  out  $clog2(ARBT_WIDTH)  index of the requester that supplied data_o
rdy_o  out  1  data_o valid
ack_i  in  1  consumer accepts data_o when rdy_o=1

Behaviour:
- Reset (rst_i=1 at a clk_i edge) drives these values:
  - rdy_o=0, data_o=RESET_VAL, idx_o=0.
  - Credit counter=0, owner-valid=0, last owner pointer=ARBT_WIDTH-1, so requester 0 has top priority first.
  - gnt_o is forced all-zero while rst_i=1.
- Capture condition: cap = (!rdy_o || ack_i) && (any req_i) && !rst_i.
  - On cap, gnt_o[win]=1 in the same cycle; every other gnt_o bit is 0.
  - Next edge: data_o<=data_i[win], idx_o<=win, rdy_o<=1.
- Drain: rdy_o && ack_i && no capture -> rdy_o<=0 next edge. data_o and idx_o hold their values.
- Stall: rdy_o && !ack_i -> data_o, idx_o and rdy_o are stable; gnt_o is all-zero.
- ack_i while rdy_o=0 is ignored.
- Throughput: ack_i held high with requests pending gives a back-to-back capture every cycle; latency is 1 cycle from capture to rdy_o.
- Winner selection, fixed priority (mode_i=1):
  - win = lowest index with req_i=1.
  - Credit counter cleared and owner-valid cleared on each capture.
  - The pointer still records win.
- Winner selection, weighted RR (mode_i=0):
  - Burst continuation: if owner-valid and credit>0 and req_i[owner]=1, then win=owner and credit decrements.
  - Otherwise win is the first requester found searching from pointer+1 upward, wrapping modulo ARBT_WIDTH, ending at the pointer itself.
    - On such a fresh win: pointer<=win, owner-valid<=1, credit<=max(wght_i[win],1)-1.
  - When credit reaches 0, owner-valid clears; the next capture does a fresh search, so the owner has lowest priority.
  - If the owner drops req_i mid-burst, the burst is abandoned. Remaining credit is discarded at the next capture, which does a fresh search from pointer+1.
  - wght_i is sampled only on a fresh win; later changes do not affect the running burst.
- Mode change: mode_i is sampled per capture. 1->0 starts a fresh RR search from the current pointer. 0->1 abandons any burst.
- Wrap: with pointer=ARBT_WIDTH-1 the search starts at 0. For non-power-of-two ARBT_WIDTH, pointer values >= ARBT_WIDTH are unreachable.
- Reset mid-burst or mid-stall: the pending data_o is dropped, rdy_o=0, and all state returns to the reset values.
- Required assertions:
  - gnt_o is onehot0.
  - gnt_o[i] implies req_i[i].
  - rdy_o && !ack_i implies data_o and idx_o are stable next cycle.
  - The credit counter never underflows.

Test Plan:
- Reset, then req_i={1,1,1,1}, all weights 1, mode_i=0, ack_i=1 -> gnt order 0,1,2,3,0; rdy_o=1 from the cycle after the first gnt; idx_o follows 0,1,2,3 one cycle late.
- wght_i={3,1,2,1}, all requesting, ack_i=1 -> idx_o sequence 0,0,0,1,2,2,3,0,0,0.
- Requester 0 with weight 4 drops req_i after 2 grants, req 2 active -> third capture goes to requester 2; later, at its next turn, requester 0 gets a fresh credit of 3.
- rdy_o=1 and ack_i=0 for 5 cycles with all requesting -> gnt_o all-zero, data_o stable; when ack_i=1, the next winner is captured that cycle and its data appears one cycle later.
- mode_i=1 with req_i={0,1,1,0} for 3 cycles -> requester 1 granted 3 times. Then mode_i=0 -> requester 2 granted next, since the pointer is at 1.
- ARBT_WIDTH=3, all requesting, weights 1 -> grants wrap 0,1,2,0. Assert rst_i mid-stream -> rdy_o=0 and data_o=RESET_VAL next cycle, and the first grant after reset goes to requester 0.
